rf_wport_sched: RTL

//  Schedules the single register-file write port between two sources: the in-order WB stage and the

---
 rtl/cpu_rf_pkg.sv | 14 +
 rtl/rf_wport_sched_if.sv | 28 ++
 rtl/rf_scoreboard.sv | 33 +++
 rtl/rf_wport_sched.sv | 95 +++++++++
 4 files changed

// File: rtl/cpu_rf_pkg.sv
// Shared register-file types for the write-port scheduler and its scoreboard.
package cpu_rf_pkg;
  localparam int DATA_W    = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [NREG-1:0]      reg_mask_t;
  typedef logic [DATA_W-1:0]    data_t;

  function automatic reg_mask_t idx_mask(input reg_idx_t idx);
    return reg_mask_t'(1) << idx;
  endfunction
endpackage

// File: rtl/rf_wport_sched_if.sv
// Write-port bundle: WB source, long-latency source and the resulting RF write.
interface rf_wport_sched_if;
  import cpu_rf_pkg::*;

  // lat_valid/dst/data are held by the source until lat_valid && lat_ready;
  // lat_ready is combinational and a transfer completes on that cycle's edge.
  // pipe_wr has no ready: the WB stage is never back-pressured.
  logic     pipe_wr;
  reg_idx_t pipe_dst;
  data_t    pipe_data;
  logic     lat_valid;
  reg_idx_t lat_dst;
  data_t    lat_data;
  logic     lat_ready;
  logic     rf_wr;
  reg_idx_t rf_dst;
  data_t    rf_data;

  modport master (
    output pipe_wr, pipe_dst, pipe_data, lat_valid, lat_dst, lat_data,
    input  lat_ready, rf_wr, rf_dst, rf_data
  );

  modport slave (
    input  pipe_wr, pipe_dst, pipe_data, lat_valid, lat_dst, lat_data,
    output lat_ready, rf_wr, rf_dst, rf_data
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy bits for registers owed a long-latency write; a same-cycle set beats a clear.
module rf_scoreboard
  import cpu_rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_idx_t  set_idx,
  input  logic      clr_en,
  input  reg_idx_t  clr_idx,
  input  reg_idx_t  rd_a_idx,
  input  reg_idx_t  rd_b_idx,
  output logic      rd_a,
  output logic      rd_b,
  output reg_mask_t busy
);
  reg_mask_t busy_next;

  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next = busy_next & ~idx_mask(clr_idx);
    if (set_en) busy_next = busy_next | idx_mask(set_idx);
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign rd_a = busy[rd_a_idx];
  assign rd_b = busy[rd_b_idx];
endmodule

// File: rtl/rf_wport_sched.sv
// Arbitrates the single RF write port between WB and the long-latency return,
// tracks outstanding writes and raises ID stalls and the anti-starvation hold.
module rf_wport_sched
  import cpu_rf_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_wport_sched_if.slave   wp,
  input  logic              iss_valid,
  input  reg_idx_t          iss_dst,
  input  reg_idx_t          id_rs,
  input  reg_idx_t          id_rt,
  input  reg_idx_t          id_dst,
  input  logic              id_dst_wr,
  output logic              id_stall,
  output logic              pipe_hold,
  output reg_mask_t         busy_vec,
  output logic              sb_err
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic             pipe_real;
  logic             lat_fire;
  logic             busy_rs;
  logic             busy_rt;
  logic             raw_rs;
  logic             raw_rt;
  logic             waw;
  logic             sb_set;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_next;

  // Writes to r0 are dropped, so they never take the port from the lat source.
  assign pipe_real    = wp.pipe_wr && (wp.pipe_dst != '0);
  assign wp.lat_ready = !pipe_real;
  assign lat_fire     = wp.lat_valid && !pipe_real;

  always_comb begin
    wp.rf_wr   = 1'b0;
    wp.rf_dst  = '0;
    wp.rf_data = '0;
    if (pipe_real) begin
      wp.rf_wr   = 1'b1;
      wp.rf_dst  = wp.pipe_dst;
      wp.rf_data = wp.pipe_data;
    end else if (lat_fire && (wp.lat_dst != '0)) begin
      wp.rf_wr   = 1'b1;
      wp.rf_dst  = wp.lat_dst;
      wp.rf_data = wp.lat_data;
    end
  end

  // A lat write landing this cycle is forwarded by the RF, so it cancels a RAW.
  assign raw_rs   = busy_rs && (id_rs != '0) && !(lat_fire && (wp.lat_dst == id_rs));
  assign raw_rt   = busy_rt && (id_rt != '0) && !(lat_fire && (wp.lat_dst == id_rt));
  assign waw      = id_dst_wr && (id_dst != '0) && busy_vec[id_dst];
  assign id_stall = raw_rs || raw_rt || waw;
  assign sb_set   = iss_valid && !id_stall && (iss_dst != '0);

  rf_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_idx  (iss_dst),
    .clr_en   (lat_fire),
    .clr_idx  (wp.lat_dst),
    .rd_a_idx (id_rs),
    .rd_b_idx (id_rt),
    .rd_a     (busy_rs),
    .rd_b     (busy_rt),
    .busy     (busy_vec)
  );

  always_comb begin
    wait_next = '0;
    if (wp.lat_valid && pipe_real)
      wait_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      pipe_hold <= 1'b0;
      sb_err    <= 1'b0;
    end else begin
      wait_cnt  <= wait_next;
      pipe_hold <= (wait_next == CNT_MAX);
      if (lat_fire && (wp.lat_dst != '0) && !busy_vec[wp.lat_dst])
        sb_err <= 1'b1;
    end
  end
endmodule
